// File: rtl/usb_fx3_pkg.sv
// Shared FX3 slave-FIFO definitions: writer state encoding, thread
// addresses and strobe polarities.
package usb_fx3_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      SETTLE = 2'd2
   } fx3_state_t;

   localparam logic [1:0] FIFO_ADDR_WR = 2'b00;
   localparam logic [1:0] FIFO_ADDR_RD = 2'b11;

   // FX3 control strobes are active-low
   localparam logic STROBE_ON  = 1'b0;
   localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/usb_burst_counter.sv
// Words-per-burst counter; terminal flags that the next accepted word
// completes the burst.
module usb_burst_counter
   import usb_fx3_pkg::*;
#(
   parameter int unsigned MAX = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic terminal
);

   localparam int unsigned CW = $clog2(MAX + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc)
         count <= count + 1'b1;
   end

   assign terminal = (count == CW'(MAX - 1));

endmodule

// File: rtl/usb_stream_in_writer.sv
// Streams upstream 32-bit words into an FX3 slave-FIFO write thread in
// bursts of at most BURST_LEN words, ending short packets with pktend.
module usb_stream_in_writer
   import usb_fx3_pkg::*;
#(
   parameter int unsigned BURST_LEN = 1024,
   parameter int unsigned FLAG_LAT  = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_valid,
   input  logic [31:0] s_data,
   input  logic        s_last,
   output logic        s_ready,
   input  logic        flag_a,
   output logic        slcs,
   output logic        slwr,
   output logic        slrd,
   output logic        sloe,
   output logic        pktend,
   output logic [1:0]  fifo_addr,
   output logic [31:0] usb_data,
   output logic        usb_data_oe,
   output logic        busy
);

   fx3_state_t state, state_nx;
   logic       hs;
   logic       term;
   logic       burst_end;
   logic       settle_done;
   logic [2:0] settle_cnt;

   assign slcs      = STROBE_ON;
   assign slrd      = STROBE_OFF;
   assign sloe      = STROBE_OFF;
   assign fifo_addr = FIFO_ADDR_WR;

   assign s_ready     = (state == WRITE);
   assign busy        = (state != IDLE);
   assign hs          = s_valid && s_ready;
   assign burst_end   = hs && (s_last || term);
   assign settle_done = (settle_cnt == 3'(FLAG_LAT - 1));

   usb_burst_counter #(
      .MAX (BURST_LEN)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (hs),
      .clr      (burst_end),
      .terminal (term)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // flag_a is only consulted from IDLE; a burst never overruns the buffer
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (flag_a && s_valid) state_nx = WRITE;
         WRITE:   if (burst_end)         state_nx = SETTLE;
         SETTLE:  if (settle_done)       state_nx = IDLE;
         default:                        state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         settle_cnt <= '0;
      else if (state != SETTLE)
         settle_cnt <= '0;
      else
         settle_cnt <= settle_cnt + 1'b1;
   end

   // pktend can only fall together with slwr, so no zero-length packets
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slwr        <= STROBE_OFF;
         pktend      <= STROBE_OFF;
         usb_data    <= '0;
         usb_data_oe <= 1'b0;
      end else begin
         slwr   <= hs ? STROBE_ON : STROBE_OFF;
         pktend <= (hs && s_last) ? STROBE_ON : STROBE_OFF;
         if (hs)
            usb_data <= s_data;
         if (hs)
            usb_data_oe <= 1'b1;
         else if (state == SETTLE && settle_done)
            usb_data_oe <= 1'b0;
      end
   end

endmodule

// File: tb/tb_usb_stream_in_writer.sv
// Randomized and directed bench for usb_stream_in_writer against a
// burst-level reference model.
module tb_usb_stream_in_writer;

   localparam int unsigned BL = 4;
   localparam int unsigned FL = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_valid = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_last = 1'b0;
   logic        s_ready;
   logic        flag_a = 1'b0;
   logic        slcs, slwr, slrd, sloe, pktend;
   logic [1:0]  fifo_addr;
   logic [31:0] usb_data;
   logic        usb_data_oe;
   logic        busy;

   usb_stream_in_writer #(
      .BURST_LEN (BL),
      .FLAG_LAT  (FL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_last      (s_last),
      .s_ready     (s_ready),
      .flag_a      (flag_a),
      .slcs        (slcs),
      .slwr        (slwr),
      .slrd        (slrd),
      .sloe        (sloe),
      .pktend      (pktend),
      .fifo_addr   (fifo_addr),
      .usb_data    (usb_data),
      .usb_data_oe (usb_data_oe),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned obs_writes;
   int unsigned obs_pend;

   // reference model: burst open flag, words taken, remaining cool-down cycles
   bit          m_open;
   int unsigned m_words;
   int unsigned m_cool;
   bit          e_slwr, e_pktend, e_oe;
   logic [31:0] e_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      m_open = 0; m_words = 0; m_cool = 0;
      e_slwr = 1; e_pktend = 1; e_oe = 0; e_data = '0;
   endtask

   task automatic model_update(input bit v, input logic [31:0] d, input bit l,
                               input bit f, input bit hs);
      e_slwr   = !hs;
      e_pktend = !(hs && l);
      if (hs) begin
         e_data = d;
         e_oe   = 1;
      end
      if (m_open) begin
         if (hs) begin
            m_words++;
            if (l || m_words == BL) begin
               m_open  = 0;
               m_words = 0;
               m_cool  = FL;
            end
         end
      end else if (m_cool > 0) begin
         m_cool--;
         if (m_cool == 0) e_oe = 0;
      end else if (f && v) begin
         m_open  = 1;
         m_words = 0;
      end
   endtask

   task automatic step(input bit v, input logic [31:0] d, input bit l, input bit f);
      bit hs;
      @(negedge clk);
      s_valid = v; s_data = d; s_last = l; flag_a = f;
      #1;
      chk("s_ready", {31'd0, s_ready}, {31'd0, m_open});
      hs = m_open && v;
      @(posedge clk);
      model_update(v, d, l, f, hs);
      #1;
      chk("slwr", {31'd0, slwr}, {31'd0, e_slwr});
      chk("pktend", {31'd0, pktend}, {31'd0, e_pktend});
      chk("usb_data", usb_data, e_data);
      chk("usb_data_oe", {31'd0, usb_data_oe}, {31'd0, e_oe});
      chk("busy", {31'd0, busy}, {31'd0, (m_open || m_cool > 0)});
      chk("pktend_without_slwr", {31'd0, (!pktend && slwr)}, 32'd0);
      if (!slwr) obs_writes++;
      if (!pktend) obs_pend++;
   endtask

   task automatic send_word(input logic [31:0] d, input bit l, input bit f);
      bit taken;
      for (int i = 0; i < 20; i++) begin
         taken = m_open;
         step(1, d, l, f);
         if (taken) return;
      end
      chk("send_timeout", 32'd1, 32'd0);
   endtask

   task automatic idle_steps(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step(0, $urandom, 0, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1; s_valid = 1; flag_a = 1;
      #1;
      chk("rst_slwr", {31'd0, slwr}, 32'd1);
      chk("rst_pktend", {31'd0, pktend}, 32'd1);
      chk("rst_oe", {31'd0, usb_data_oe}, 32'd0);
      chk("rst_ready", {31'd0, s_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_data", usb_data, 32'd0);
      model_reset();
      @(negedge clk);
      rst = 0; s_valid = 0;
   endtask

   task automatic scen_check(input string tag, input int unsigned w, input int unsigned p);
      chk({tag, "_writes"}, obs_writes, w);
      chk({tag, "_pktend"}, obs_pend, p);
      obs_writes = 0; obs_pend = 0;
   endtask

   initial begin
      model_reset();
      obs_writes = 0; obs_pend = 0;
      do_reset();
      chk("slcs", {31'd0, slcs}, 32'd0);
      chk("slrd", {31'd0, slrd}, 32'd1);
      chk("sloe", {31'd0, sloe}, 32'd1);
      chk("fifo_addr", {30'd0, fifo_addr}, 32'd0);

      // full burst without s_last
      for (int i = 1; i <= 4; i++) send_word(32'h11 * i, 0, 1);
      idle_steps(6);
      scen_check("full", 4, 0);

      // short packet
      send_word(32'hA0, 0, 1);
      send_word(32'hA1, 1, 1);
      idle_steps(6);
      scen_check("short", 2, 1);

      // FIFO full: nothing may be written
      for (int i = 0; i < 10; i++) step(1, 32'hDEAD_0000 + i, 0, 0);
      scen_check("full_flag", 0, 0);
      send_word(32'hB0, 1, 1);
      idle_steps(6);
      scen_check("flag_release", 1, 1);

      // bubbles inside a burst
      send_word(32'hC0, 0, 1);
      idle_steps(2);
      send_word(32'hC1, 0, 1);
      send_word(32'hC2, 0, 1);
      idle_steps(1);
      send_word(32'hC3, 0, 1);
      idle_steps(6);
      scen_check("bubbles", 4, 0);

      // s_last coincides with the BURST_LEN-th word
      for (int i = 0; i < 3; i++) send_word(32'hD0 + i, 0, 1);
      send_word(32'hD3, 1, 1);
      idle_steps(6);
      scen_check("coincident", 4, 1);

      // reset mid-burst, then a fresh burst must count from zero
      send_word(32'hE0, 0, 1);
      send_word(32'hE1, 0, 1);
      do_reset();
      obs_writes = 0; obs_pend = 0;
      for (int i = 0; i < 4; i++) send_word(32'hF0 + i, 0, 1);
      idle_steps(6);
      scen_check("after_reset", 4, 0);

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0)
            do_reset();
         else
            step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) < 8);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
